lap_recall_reader: RTL and testbench
====================================

Name: lap_recall_reader

Overview:
Read-side counterpart of the stopwatch lap-record writer. It steps through lap records already stored in the 16-entry lap RAM and shows one at a time on the display. It issues RAM reads with a fixed read latency, captures the returned 24-bit BCD time, and drives the display mux. It sits between the key inputs, the lap RAM read port and the 7-segment display path.

Parameters:
DATA_W, 24, width of a lap record (6 BCD digits).
ADDR_W, 4, RAM address width.
ADDR_BASE, 1, RAM address of record 0; record n is at (ADDR_BASE + n) mod 2^ADDR_W.
RD_LAT, 2, cycles from rd_en to valid ram_q. Legal values are 1..3.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
key_next  in  1  raw level from the "recall/next" key, asynchronous to clk
key_exit  in  1  raw level from the "exit recall" key, asynchronous to clk
wr_count  in  ADDR_W  number of valid records stored, 0..15, from the writer
ram_q  in  DATA_W  lap RAM read data
watch_data  in  DATA_W  live stopwatch count
rd_address  out  ADDR_W  lap RAM read address
rd_en  out  1  one-cycle read strobe
rec_index  out  ADDR_W  index of the record shown
disp_out  out  DATA_W  display data
disp_sel  out  1  1 = showing a recalled record, 0 = showing the live count
busy  out  1  read in flight (ISSUE or WAIT)

Behaviour:
- Key conditioning:
  - Each key passes through a 2-flop synchronizer, then a rising-edge detector.
  - This gives next_p and exit_p, each a one-cycle pulse.
  - Latency from the key edge to the pulse is 3 clk.
- Reset values:
  - FSM in IDLE.
  - rd_address=0, rd_en=0, rec_index=0, disp_sel=0, busy=0.
  - Captured data register = 0; pending flag = 0.
  - Synchronizer flops = 0, so a key held high through reset produces one pulse after reset releases.
- disp_out = disp_sel ? captured_data : watch_data. This is combinational from registered disp_sel.
- FSM states: IDLE, ISSUE, WAIT, SHOW.
- IDLE:
  - next_p with wr_count != 0: rec_index <= wr_count-1 (newest record), go to ISSUE.
  - next_p with wr_count == 0: ignored, stay in IDLE.
  - exit_p: no effect.
- ISSUE (1 cycle):
  - rd_address <= ADDR_BASE + rec_index (mod 16).
  - rd_en=1 for this cycle only. busy=1.
  - Go to WAIT; the latency counter loads RD_LAT-1.
- WAIT:
  - rd_address is held stable. busy=1.
  - The counter decrements each cycle.
  - On the cycle the counter is 0, ram_q is valid: captured_data <= ram_q, disp_sel <= 1, go to SHOW.
  - Total latency: disp_out shows the new record RD_LAT+1 cycles after the ISSUE cycle.
- SHOW:
  - next_p: rec_index <= (rec_index == 0) ? wr_count-1 : rec_index-1, go to ISSUE.
  - Stepping order is newest to oldest, then wraps to newest.
- Keys arriving during ISSUE/WAIT:
  - next_p sets the one-deep pending flag; further next_p while it is set are dropped.
  - On entering SHOW with pending=1: clear it and step immediately, as if next_p occurred in that cycle.
  - disp_sel still rises for one or more cycles before the next read.
- exit_p in any non-IDLE state:
  - Go to IDLE; disp_sel <= 0; pending <= 0.
  - Any in-flight read is discarded; captured_data is not updated.
- Simultaneous next_p and exit_p: exit wins.
- wr_count change while not IDLE:
  - Checked every cycle.
  - If wr_count == 0 or rec_index >= wr_count: go to IDLE and set disp_sel <= 0. This has the same priority as exit.
  - Growth of wr_count does not move rec_index.
- rst mid-read: immediate return to reset values. The RAM data still arriving is ignored.
- rd_en is never asserted outside ISSUE. There is at most one outstanding read.

Decomposition:
- Shared package stopwatch_pkg holds:
  - DATA_W and ADDR_W constants.
  - FSM state encoding (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, SHOW=2'b11).
  - ADDR_BASE, so the writer and this reader agree on the record layout.
- One sub-module: key_edge_sync (2-flop synchronizer plus rising-edge pulse), instantiated twice.

Test Plan:
1. Reset, wr_count=0, pulse key_next -> stays IDLE, rd_en never asserted, disp_sel=0, disp_out=watch_data.
2. RD_LAT=2, wr_count=3, RAM[1..3]=0x000123/0x000456/0x000789, press key_next:
   - rd_address=4'd3, one rd_en pulse.
   - 3 cycles after ISSUE: disp_out=0x000789, disp_sel=1, rec_index=2.
3. From case 2, press next three times -> rec_index 1, 0, 2 with disp_out 0x000456, 0x000123, 0x000789 (wrap-around).
4. Press next twice within WAIT -> exactly two reads total: the first, plus one from pending; the second extra press is dropped; final rec_index=1.
5. During WAIT, press key_next and key_exit in the same cycle -> IDLE, disp_sel=0, captured_data unchanged, no further rd_en.
6. In SHOW with rec_index=2, set wr_count=2 -> next cycle IDLE, disp_sel=0. Also assert rst during WAIT -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: record geometry, lap RAM layout and the
// recall-reader FSM encoding. The lap-record writer and the recall reader
// both import this package so they agree on where record n lives.
package stopwatch_pkg;

  localparam int DATA_W = 24;  // six BCD digits per lap record
  localparam int ADDR_W = 4;   // 16-entry lap RAM

  // RAM address of record 0; record n sits at (ADDR_BASE + n) mod 2^ADDR_W.
  localparam logic [ADDR_W-1:0] ADDR_BASE = 4'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_SHOW  = 2'b11
  } state_t;

  // Map a record index to its RAM address. The sum wraps naturally at ADDR_W bits.
  function automatic logic [ADDR_W-1:0] rec_addr(input logic [ADDR_W-1:0] idx);
    return ADDR_BASE + idx;
  endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Key conditioner: a 2-flop synchronizer, then a registered rising-edge
// detector. A key edge produces a one-cycle pulse 3 clk later.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   key   - raw key level, asynchronous to clk
//   pulse - one-cycle pulse on each rising edge of key
module key_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic pulse
);

  logic meta;
  logic sync;
  logic prev;

  // All flops clear to 0. A key held high through reset therefore looks like
  // a fresh press once reset releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each stage sample the previous
      // stage's old value, which gives a real flop chain and not a wire.
      meta  <= key;
      sync  <= meta;
      prev  <= sync;
      pulse <= sync & ~prev;
    end
  end

endmodule

// File: rtl/lap_recall_reader.sv
// Lap recall reader: steps through stored lap records from newest to oldest
// and wraps to the newest. For each step it issues one lap RAM read with a
// fixed latency and shows the captured record on the display. When not
// recalling, the live stopwatch count is shown.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   key_next, key_exit - raw key levels, asynchronous to clk
//   wr_count           - number of valid records held by the writer
//   ram_q              - lap RAM read data, valid RD_LAT cycles after rd_en
//   watch_data         - live stopwatch count
//   rd_address, rd_en  - lap RAM read port
//   rec_index          - index of the record being shown
//   disp_out, disp_sel - display data; disp_sel=1 while a record is shown
//   busy               - a read is in flight (ISSUE or WAIT)
module lap_recall_reader #(
  parameter int DATA_W                 = stopwatch_pkg::DATA_W,
  parameter int ADDR_W                 = stopwatch_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] ADDR_BASE = stopwatch_pkg::ADDR_BASE,
  parameter int RD_LAT                 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_next,
  input  logic              key_exit,
  input  logic [ADDR_W-1:0] wr_count,
  input  logic [DATA_W-1:0] ram_q,
  input  logic [DATA_W-1:0] watch_data,
  output logic [ADDR_W-1:0] rd_address,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rec_index,
  output logic [DATA_W-1:0] disp_out,
  output logic              disp_sel,
  output logic              busy
);

  import stopwatch_pkg::*;

  logic next_p;
  logic exit_p;

  key_edge_sync u_sync_next (.clk(clk), .rst(rst), .key(key_next), .pulse(next_p));
  key_edge_sync u_sync_exit (.clk(clk), .rst(rst), .key(key_exit), .pulse(exit_p));

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;      // enough for RD_LAT up to 3
  logic [DATA_W-1:0] captured_data, cap_d;
  logic              pending, pend_d;
  logic [ADDR_W-1:0] rec_d, addr_d;
  logic              sel_d;
  logic              abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      captured_data <= '0;
      pending       <= 1'b0;
      rec_index     <= '0;
      rd_address    <= '0;
      disp_sel      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      captured_data <= cap_d;
      pending       <= pend_d;
      rec_index     <= rec_d;
      rd_address    <= addr_d;
      disp_sel      <= sel_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so that no path through
    // the case leaves one unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = captured_data;
    pend_d  = pending;
    rec_d   = rec_index;
    addr_d  = rd_address;
    sel_d   = disp_sel;

    // Exit, an emptied RAM, or a shown index the writer no longer holds all
    // abandon recall. They share one priority and override any step.
    abort = (state_q != ST_IDLE) &&
            (exit_p || (wr_count == '0) || (rec_index >= wr_count));

    unique case (state_q)
      ST_IDLE: begin
        if (next_p && (wr_count != '0)) begin
          rec_d   = wr_count - 1'b1;
          addr_d  = rec_addr(rec_d);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (next_p) pend_d = 1'b1;
        cnt_d   = 2'(RD_LAT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (next_p) pend_d = 1'b1;
        if (cnt_q == '0) begin
          cap_d   = ram_q;
          sel_d   = 1'b1;
          state_d = ST_SHOW;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SHOW: begin
        // A press queued during the read steps here, after disp_sel has
        // already been high for at least this cycle.
        if (next_p || pending) begin
          pend_d  = 1'b0;
          rec_d   = (rec_index == '0) ? wr_count - 1'b1 : rec_index - 1'b1;
          addr_d  = rec_addr(rec_d);
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      sel_d   = 1'b0;
      pend_d  = 1'b0;
      rec_d   = rec_index;
      addr_d  = rd_address;
      cap_d   = captured_data;
    end
  end

  // The read address is loaded on entry to ISSUE, so it is already valid
  // while the strobe is high and stays put through WAIT.
  assign rd_en    = (state_q == ST_ISSUE);
  assign busy     = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign disp_out = disp_sel ? captured_data : watch_data;

endmodule

// File: tb/tb_lap_recall_reader.sv
module tb_lap_recall_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_next = 1'b0;
  logic        key_exit = 1'b0;
  logic [3:0]  wr_count = 4'd0;
  logic [23:0] watch_data = 24'hABCDEF;

  logic [23:0] ram_q, ram_q3;
  logic [3:0]  rd_address, rd_address3, rec_index, rec_index3;
  logic        rd_en, rd_en3, disp_sel, disp_sel3, busy, busy3;
  logic [23:0] disp_out, disp_out3;

  logic [23:0] mem [16];
  logic [23:0] p1, q3a, q3b;
  int          rd_cnt  = 0;
  int          rd_cnt3 = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  lap_recall_reader #(.RD_LAT(2)) dut (
    .clk(clk), .rst(rst), .key_next(key_next), .key_exit(key_exit),
    .wr_count(wr_count), .ram_q(ram_q), .watch_data(watch_data),
    .rd_address(rd_address), .rd_en(rd_en), .rec_index(rec_index),
    .disp_out(disp_out), .disp_sel(disp_sel), .busy(busy)
  );

  // A second instance with a longer read latency leaves room for two queued
  // presses inside one read.
  lap_recall_reader #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .key_next(key_next), .key_exit(key_exit),
    .wr_count(wr_count), .ram_q(ram_q3), .watch_data(watch_data),
    .rd_address(rd_address3), .rd_en(rd_en3), .rec_index(rec_index3),
    .disp_out(disp_out3), .disp_sel(disp_sel3), .busy(busy3)
  );

  // Lap RAM models: data for the current address emerges 2 or 3 cycles later.
  always @(posedge clk) begin
    p1     <= mem[rd_address];
    ram_q  <= p1;
    q3a    <= mem[rd_address3];
    q3b    <= q3a;
    ram_q3 <= q3b;
    if (rd_en)  rd_cnt  <= rd_cnt + 1;
    if (rd_en3) rd_cnt3 <= rd_cnt3 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    key_next = 1'b0;
    key_exit = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic press_next();
    key_next = 1'b1;
    tick();
    key_next = 1'b0;
  endtask

  // Wait for a read to start and then finish on the RD_LAT=2 instance.
  task automatic wait_show(input string tag);
    int n = 0;
    while (!busy && n < 20) begin tick(); n++; end
    while (busy && n < 40) begin tick(); n++; end
    check({tag, "_timeout"}, 32'(n < 40), 32'd1);
  endtask

  task automatic wait_rd_en(input string tag);
    int n = 0;
    while (!rd_en && n < 20) begin tick(); n++; end
    check({tag, "_timeout"}, 32'(n < 20), 32'd1);
  endtask

  initial begin
    int base;
    for (int i = 0; i < 16; i++) mem[i] = 24'h900000 + 24'(i);
    mem[0] = 24'hDEAD00;
    mem[1] = 24'h000123;
    mem[2] = 24'h000456;
    mem[3] = 24'h000789;

    // Reset values
    do_reset();
    check("rst_rd_address", 32'(rd_address), 32'd0);
    check("rst_rec_index",  32'(rec_index),  32'd0);
    check("rst_disp_sel",   32'(disp_sel),   32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_rd_en",      32'(rd_en),      32'd0);

    // 1: empty RAM, next is ignored
    base = rd_cnt;
    press_next();
    repeat (8) tick();
    check("empty_no_read",  32'(rd_cnt - base), 32'd0);
    check("empty_busy",     32'(busy),     32'd0);
    check("empty_disp_sel", 32'(disp_sel), 32'd0);
    check("empty_disp_out", 32'(disp_out), 32'hABCDEF);

    // 2: first recall shows the newest record with exact latency
    wr_count = 4'd3;
    base = rd_cnt;
    press_next();
    wait_rd_en("first_issue");
    check("first_rd_address", 32'(rd_address), 32'd3);
    tick();
    check("first_single_strobe", 32'(rd_en), 32'd0);
    tick();
    check("first_not_yet", 32'(disp_sel), 32'd0);
    tick();
    check("first_disp_out", 32'(disp_out), 32'h000789);
    check("first_disp_sel", 32'(disp_sel), 32'd1);
    check("first_rec_index", 32'(rec_index), 32'd2);
    check("first_read_count", 32'(rd_cnt - base), 32'd1);

    // 3: step newest to oldest, then wrap
    press_next(); wait_show("step1");
    check("step1_rec", 32'(rec_index), 32'd1);
    check("step1_out", 32'(disp_out),  32'h000456);
    press_next(); wait_show("step0");
    check("step0_rec", 32'(rec_index), 32'd0);
    check("step0_out", 32'(disp_out),  32'h000123);
    press_next(); wait_show("wrap");
    check("wrap_rec",  32'(rec_index), 32'd2);
    check("wrap_out",  32'(disp_out),  32'h000789);

    // 4: two extra presses during one read: one queued, one dropped
    do_reset();
    base = rd_cnt3;
    key_next = 1'b1; tick();
    key_next = 1'b0; tick();
    key_next = 1'b1; tick();
    key_next = 1'b0; tick();
    key_next = 1'b1; tick();
    key_next = 1'b0;
    repeat (25) tick();
    check("pend_read_count", 32'(rd_cnt3 - base), 32'd2);
    check("pend_rec_index",  32'(rec_index3), 32'd1);
    check("pend_disp_out",   32'(disp_out3),  32'h000456);
    check("pend_disp_sel",   32'(disp_sel3),  32'd1);

    // 5: next and exit together during WAIT, exit wins and the read is dropped
    do_reset();
    press_next();
    wait_show("exit_setup");
    check("exit_setup_out", 32'(disp_out), 32'h000789);
    base = rd_cnt;
    key_next = 1'b1; tick();
    key_next = 1'b0; tick();
    key_next = 1'b1; key_exit = 1'b1; tick();
    key_next = 1'b0; key_exit = 1'b0;
    repeat (8) tick();
    check("exit_busy",     32'(busy),     32'd0);
    check("exit_disp_sel", 32'(disp_sel), 32'd0);
    check("exit_disp_out", 32'(disp_out), 32'hABCDEF);
    check("exit_captured", 32'(dut.captured_data), 32'h000789);
    check("exit_one_read", 32'(rd_cnt - base), 32'd1);

    // 6a: writer shrinks below the shown index
    do_reset();
    press_next();
    wait_show("shrink_setup");
    check("shrink_setup_rec", 32'(rec_index), 32'd2);
    wr_count = 4'd2;
    tick();
    check("shrink_disp_sel", 32'(disp_sel), 32'd0);
    check("shrink_disp_out", 32'(disp_out), 32'hABCDEF);
    repeat (4) tick();
    check("shrink_stays_idle", 32'(busy), 32'd0);

    // 6b: reset in the middle of a read
    wr_count = 4'd3;
    press_next();
    wait_rd_en("rst_mid_issue");
    tick();
    check("rst_mid_in_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("rst_mid_rd_address", 32'(rd_address), 32'd0);
    check("rst_mid_rec_index",  32'(rec_index),  32'd0);
    check("rst_mid_rd_en",      32'(rd_en),      32'd0);
    check("rst_mid_busy",       32'(busy),       32'd0);
    check("rst_mid_disp_sel",   32'(disp_sel),   32'd0);
    rst = 1'b0;
    repeat (5) tick();
    check("rst_mid_ignored",    32'(disp_sel),   32'd0);
    check("rst_mid_out",        32'(disp_out),   32'hABCDEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
